// File: rtl/screen_sequencer.sv
// Game-phase timer: steps curr_screen through NUM_SCREENS screens, each held for a programmable number of seconds.
// Latency: all outputs are registered and change one cycle after the qualifying edge or input.
// Backpressure: none; pause freezes the second prescaler and countdown, and skip ends the current screen at once.
module screen_sequencer #(
  parameter int NUM_SCREENS = 4,
  parameter int SCR_W       = 2,
  parameter int TIME_W      = 8,
  parameter int CLK_HZ      = 50000000,
  parameter int LOOP        = 0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          pause,
  input  logic                          skip,
  input  logic [NUM_SCREENS*TIME_W-1:0] durations,
  output logic [SCR_W-1:0]              curr_screen,
  output logic [TIME_W-1:0]             seconds_left,
  output logic                          tick,
  output logic                          screen_change,
  output logic                          running,
  output logic                          end_of_game
);

  localparam int                 PRE_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRE_W-1:0]   PRE_TC = PRE_W'(CLK_HZ - 1);
  localparam logic [SCR_W-1:0]   LAST   = SCR_W'(NUM_SCREENS - 1);
  localparam logic [TIME_W-1:0]  ONE_S  = TIME_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_DONE} state_t;

  state_t             r_state;
  logic [PRE_W-1:0]   r_prescaler;
  logic [SCR_W-1:0]   r_screen;
  logic [TIME_W-1:0]  r_secs;
  logic               r_tick;
  logic               r_sc;
  logic               r_running;
  logic               r_eog;

  logic               w_active;
  logic               w_advance;
  logic               w_tc;
  logic               w_last;
  logic               w_skip;
  logic               w_expire;
  logic [SCR_W-1:0]   w_next_screen;
  logic [TIME_W-1:0]  w_dur_raw;
  logic [TIME_W-1:0]  w_dur_next;
  logic [TIME_W-1:0]  w_dur0;

  // Expiry decode and duration fetch for whichever screen would be loaded next
  always_comb begin
    w_active      = (r_state == S_RUN) || (r_state == S_PAUSED);
    w_advance     = w_active && !pause;
    w_tc          = (r_prescaler == PRE_TC);
    w_last        = (r_screen == LAST);
    w_skip        = w_active && skip;
    // skip and a natural expiry in the same cycle collapse into one expiry
    w_expire      = w_skip || (w_advance && w_tc && (r_secs <= ONE_S));
    w_next_screen = w_last ? '0 : r_screen + 1'b1;
    w_dur_raw     = '0;
    for (int i = 0; i < NUM_SCREENS; i++) begin
      if (w_next_screen == SCR_W'(i)) begin
        w_dur_raw = durations[i*TIME_W +: TIME_W];
      end
    end
    // a zero duration still shows the screen for one full second
    w_dur_next = (w_dur_raw == '0) ? ONE_S : w_dur_raw;
    w_dur0     = (durations[TIME_W-1:0] == '0) ? ONE_S : durations[TIME_W-1:0];
  end

  // Sequencer FSM with registered screen index, countdown and pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_prescaler <= '0;
      r_screen    <= '0;
      r_secs      <= '0;
      r_tick      <= 1'b0;
      r_sc        <= 1'b0;
      r_running   <= 1'b0;
      r_eog       <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_sc   <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state     <= S_RUN;
            r_screen    <= '0;
            r_secs      <= w_dur0;
            r_prescaler <= '0;
            r_sc        <= 1'b1;
            r_running   <= 1'b1;
            r_eog       <= 1'b0;
          end
        end
        S_RUN, S_PAUSED: begin
          if (w_expire) begin
            r_prescaler <= '0;
            // a second boundary that ends the screen still ticks; a skip does not
            r_tick      <= !w_skip;
            if (w_last && (LOOP == 0)) begin
              r_state   <= S_DONE;
              r_secs    <= '0;
              r_running <= 1'b0;
              r_eog     <= 1'b1;
            end else begin
              r_screen <= w_next_screen;
              r_secs   <= w_dur_next;
              r_sc     <= 1'b1;
              // a skip taken while paused leaves the sequencer paused
              if ((r_state == S_PAUSED) && pause) begin
                r_state <= S_PAUSED;
              end else begin
                r_state <= S_RUN;
              end
            end
          end else if (w_advance) begin
            // leaving PAUSED counts this cycle, so no part of a second is lost
            r_state <= S_RUN;
            if (w_tc) begin
              r_prescaler <= '0;
              r_tick      <= 1'b1;
              r_secs      <= r_secs - ONE_S;
            end else begin
              r_prescaler <= r_prescaler + 1'b1;
            end
          end else begin
            r_state <= S_PAUSED;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign curr_screen   = r_screen;
  assign seconds_left  = r_secs;
  assign tick          = r_tick;
  assign screen_change = r_sc;
  assign running       = r_running;
  assign end_of_game   = r_eog;

endmodule

// File: tb/tb_screen_sequencer.sv
// Scoreboard bench for screen_sequencer: one one-shot instance driven through every scenario, one looping instance.
// Expected screen changes and end-of-game rises are queued with their cycle stamps and matched by monitors.
// Stimulus is applied 1 time unit after the rising edge; monitors sample on the falling edge.
module tb_screen_sequencer;

  typedef struct {
    int kind;   // 0 = screen_change pulse, 1 = end_of_game rise
    int cyc;
    int scr;
    int secs;
  } ev_t;

  logic        clock = 1'b0;
  logic        reset, reset_l;
  logic        start, start_l;
  logic        pause, skip;
  logic [31:0] durations;

  logic [1:0]  curr_screen, curr_l;
  logic [7:0]  seconds_left, secs_l;
  logic        tick, tick_l, screen_change, sc_l, running, running_l, end_of_game, eog_l;

  ev_t q[$];
  ev_t lq[$];
  int  cyc = 0;
  int  tests = 0;
  int  fails = 0;
  logic eog_prev = 1'b0;
  logic loop_eog_seen = 1'b0;

  localparam logic [31:0] D0 = {8'd3, 8'd2, 8'd1, 8'd4};
  localparam logic [31:0] D1 = {8'd3, 8'd2, 8'd0, 8'd4};

  screen_sequencer #(.NUM_SCREENS(4), .SCR_W(2), .TIME_W(8), .CLK_HZ(10), .LOOP(0)) dut (
    .clock(clock), .reset(reset), .start(start), .pause(pause), .skip(skip),
    .durations(durations), .curr_screen(curr_screen), .seconds_left(seconds_left),
    .tick(tick), .screen_change(screen_change), .running(running), .end_of_game(end_of_game)
  );

  screen_sequencer #(.NUM_SCREENS(4), .SCR_W(2), .TIME_W(8), .CLK_HZ(10), .LOOP(1)) dut_loop (
    .clock(clock), .reset(reset_l), .start(start_l), .pause(1'b0), .skip(1'b0),
    .durations(durations), .curr_screen(curr_l), .seconds_left(secs_l),
    .tick(tick_l), .screen_change(sc_l), .running(running_l), .end_of_game(eog_l)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input int scr, input int secs);
    ev_t e;
    e.kind = kind; e.cyc = c; e.scr = scr; e.secs = secs;
    q.push_back(e);
  endtask

  task automatic lpush(input int c, input int scr, input int secs);
    ev_t e;
    e.kind = 0; e.cyc = c; e.scr = scr; e.secs = secs;
    lq.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step(1);
  endtask

  // Monitor for the one-shot instance
  always @(negedge clock) begin
    ev_t e;
    if (screen_change) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_screen_change: got screen %0d secs %0d at cycle %0d, expected no event", curr_screen, seconds_left, cyc);
      end else begin
        e = q.pop_front();
        if (e.kind != 0 || e.cyc != cyc || int'(curr_screen) != e.scr || int'(seconds_left) != e.secs) begin
          fails++;
          $display("FAIL screen_change: got kind 0 cyc %0d scr %0d secs %0d, expected kind %0d cyc %0d scr %0d secs %0d",
                   cyc, curr_screen, seconds_left, e.kind, e.cyc, e.scr, e.secs);
        end
      end
    end
    if (end_of_game && !eog_prev) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_end_of_game: got rise at cycle %0d, expected no event", cyc);
      end else begin
        e = q.pop_front();
        if (e.kind != 1 || e.cyc != cyc || int'(curr_screen) != e.scr || int'(seconds_left) != e.secs || screen_change) begin
          fails++;
          $display("FAIL end_of_game: got kind 1 cyc %0d scr %0d secs %0d sc %0b, expected kind %0d cyc %0d scr %0d secs %0d sc 0",
                   cyc, curr_screen, seconds_left, screen_change, e.kind, e.cyc, e.scr, e.secs);
        end
      end
    end
    eog_prev = end_of_game;
  end

  // Monitor for the looping instance
  always @(negedge clock) begin
    ev_t e;
    if (eog_l) loop_eog_seen = 1'b1;
    if (sc_l) begin
      tests++;
      if (lq.size() == 0) begin
        fails++;
        $display("FAIL loop_unexpected_change: got screen %0d secs %0d at cycle %0d, expected no event", curr_l, secs_l, cyc);
      end else begin
        e = lq.pop_front();
        if (e.cyc != cyc || int'(curr_l) != e.scr || int'(secs_l) != e.secs) begin
          fails++;
          $display("FAIL loop_screen_change: got cyc %0d scr %0d secs %0d, expected cyc %0d scr %0d secs %0d",
                   cyc, curr_l, secs_l, e.cyc, e.scr, e.secs);
        end
      end
    end
  end

  initial begin
    int c;
    int ticks;
    int budget;
    reset = 1'b1; reset_l = 1'b1; start = 1'b0; start_l = 1'b0;
    pause = 1'b0; skip = 1'b0; durations = D0;
    step(3);
    chk("reset_screen", int'(curr_screen), 0);
    chk("reset_secs", int'(seconds_left), 0);
    chk("reset_running", int'(running), 0);
    chk("reset_eog", int'(end_of_game), 0);
    chk("reset_pulses", int'({tick, screen_change}), 0);
    reset = 1'b0; reset_l = 1'b0;
    step(2);

    // Full one-shot run alongside the looping instance
    c = cyc;
    push(0, c + 1, 0, 4); push(0, c + 41, 1, 1); push(0, c + 51, 2, 2);
    push(0, c + 71, 3, 3); push(1, c + 101, 3, 0);
    lpush(c + 1, 0, 4); lpush(c + 41, 1, 1); lpush(c + 51, 2, 2);
    lpush(c + 71, 3, 3); lpush(c + 101, 0, 4); lpush(c + 141, 1, 1);
    start = 1'b1; start_l = 1'b1;
    step(1);
    start = 1'b0; start_l = 1'b0;
    chk("start_running", int'(running), 1);
    for (int k = 0; k < 4; k++) begin
      wait_until(c + 5 + 10 * k);
      chk("screen0_countdown", int'(seconds_left), 4 - k);
    end
    wait_until(c + 102);
    chk("done_eog", int'(end_of_game), 1);
    chk("done_screen", int'(curr_screen), 3);
    chk("done_secs", int'(seconds_left), 0);
    chk("done_running", int'(running), 0);
    wait_until(c + 142);
    reset_l = 1'b1;
    chk("loop_no_eog", int'(loop_eog_seen), 0);
    step(2);

    // Restart from DONE, then pause in screen1 at prescaler 6 for 25 cycles
    c = cyc;
    push(0, c + 1, 0, 4); push(0, c + 41, 1, 1); push(0, c + 76, 2, 2);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("restart_eog_clear", int'(end_of_game), 0);
    wait_until(c + 47);
    pause = 1'b1;
    ticks = 0;
    while (cyc < c + 72) begin
      step(1);
      if (tick) ticks++;
    end
    chk("pause_no_tick", ticks, 0);
    chk("pause_secs_hold", int'(seconds_left), 1);
    chk("pause_running", int'(running), 1);
    pause = 1'b0;

    // Reset while PAUSED on screen2
    wait_until(c + 80);
    pause = 1'b1;
    wait_until(c + 85);
    chk("paused_screen2", int'(curr_screen), 2);
    reset = 1'b1;
    step(1);
    reset = 1'b0; pause = 1'b0;
    chk("rst_paused_screen", int'(curr_screen), 0);
    chk("rst_paused_secs", int'(seconds_left), 0);
    chk("rst_paused_running", int'(running), 0);
    step(2);

    // Skip on the terminal-count cycle, then skips through the last screen
    c = cyc;
    push(0, c + 1, 0, 4); push(0, c + 11, 1, 1); push(0, c + 21, 2, 2);
    push(0, c + 25, 3, 3); push(1, c + 30, 3, 0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_until(c + 10);
    skip = 1'b1;
    step(1);
    skip = 1'b0;
    chk("skip_tc_no_tick", int'(tick), 0);
    chk("skip_tc_secs", int'(seconds_left), 1);
    wait_until(c + 24);
    skip = 1'b1;
    step(1);
    skip = 1'b0;
    wait_until(c + 29);
    skip = 1'b1;
    step(1);
    skip = 1'b0;
    chk("skip_last_eog", int'(end_of_game), 1);
    chk("skip_last_running", int'(running), 0);

    // Zero duration on screen1 lasts exactly one second
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    durations = D1;
    step(1);
    c = cyc;
    push(0, c + 1, 0, 4); push(0, c + 41, 1, 1); push(0, c + 51, 2, 2);
    push(0, c + 71, 3, 3); push(1, c + 101, 3, 0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_until(c + 102);

    budget = 0;
    while ((q.size() != 0 || lq.size() != 0) && budget < 200) begin
      step(1);
      budget++;
    end
    chk("scoreboard_drained", q.size() + lq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
